// File: rtl/tx_meta_sched.sv
// tx_meta_sched: transmit-side reader of the per-port 4-queue metadata buffer.
// Picks one eligible queue by strict priority (q0 highest), issues a one-cycle
// read strobe, captures the returned metadata, offers it to the transmitter and
// waits for frame completion before the next selection.
// Optional build macro CBS_EN adds a credit-based shaper on q2.
module tx_meta_sched #(
    parameter int                 MD_TIMEOUT = 8,
    parameter int                 CNT_W      = 16,
    parameter int                 IDLE_SLOPE = 4,
    parameter logic signed [15:0] CREDIT_MAX = 16'sd2047
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           in_q_empty,
    input  logic [3:0]           in_q_gate,
    input  logic [10:0]          in_q2_pkt_len,
    output logic [3:0]           out_q_rden,
    input  logic [7:0]           in_md,
    input  logic                 in_md_wr,
    output logic [7:0]           out_md,
    output logic                 out_md_valid,
    input  logic                 in_tx_ready,
    input  logic                 in_tx_done,
    output logic [4*CNT_W-1:0]   out_q_cnt,
    output logic                 out_err_timeout
);

    localparam int TO_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT_MD,
        SEND,
        WAIT_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        sel_reg, sel_next;
    logic [1:0]        pick;
    logic [3:0]        elig_base;
    logic [3:0]        elig;
    logic [3:0]        rden_reg;
    logic [7:0]        md_reg;
    logic              md_valid_reg;
    logic              err_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic              md_take;
    logic              md_expire;
    logic              tx_xfer;

    // Raw eligibility per queue: data present and gate open.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_elig
            assign elig_base[gi] = ~in_q_empty[gi] & in_q_gate[gi];
        end
    endgenerate

`ifdef CBS_EN
    localparam logic signed [16:0] CMAX_X = 17'(CREDIT_MAX);

    logic signed [15:0] credit_reg;
    logic signed [16:0] credit_add;
    logic signed [16:0] credit_sub;
    logic               q2_sel;

    // q2 additionally needs non-negative credit.
    assign elig = {elig_base[3], elig_base[2] & ~credit_reg[15], elig_base[1:0]};

    // q2 counts as selected from the picking cycle until the FSM is idle again.
    assign q2_sel = ((state_reg == IDLE) && (|elig) && (pick == 2'd2)) ||
                    ((state_reg != IDLE) && (sel_reg == 2'd2));

    assign credit_add = 17'(credit_reg) + $signed(17'(IDLE_SLOPE));
    assign credit_sub = 17'(credit_reg) - $signed({6'd0, in_q2_pkt_len});

    // Credit: charge packet length on the q2 read, refill while q2 waits, drop positive credit when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_reg <= 16'sd0;
        end else if ((state_reg == RD) && (sel_reg == 2'd2)) begin
            if (credit_sub[16] != credit_sub[15])
                credit_reg <= 16'sh8000;
            else
                credit_reg <= credit_sub[15:0];
        end else if (in_q_empty[2] && (credit_reg > 16'sd0)) begin
            credit_reg <= 16'sd0;
        end else if (!in_q_empty[2] && !q2_sel) begin
            if (credit_add > CMAX_X)
                credit_reg <= CREDIT_MAX;
            else
                credit_reg <= credit_add[15:0];
        end
    end
`else
    logic unused_cbs;

    assign elig       = elig_base;
    assign unused_cbs = ^{in_q2_pkt_len, 16'(IDLE_SLOPE), CREDIT_MAX};
`endif

    // Strict priority encoder, q0 wins.
    always_comb begin
        pick = 2'd0;
        if (elig[0])
            pick = 2'd0;
        else if (elig[1])
            pick = 2'd1;
        else if (elig[2])
            pick = 2'd2;
        else if (elig[3])
            pick = 2'd3;
    end

    assign md_take   = (state_reg == WAIT_MD) && in_md_wr;
    assign md_expire = (state_reg == WAIT_MD) && !in_md_wr && (to_cnt_reg == TO_LAST);
    assign tx_xfer   = (state_reg == SEND) && in_tx_ready;

    // State and selected-queue registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sel_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
        end
    end

    // Next-state logic; selection is only latched when leaving IDLE.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        case (state_reg)
            IDLE: begin
                if (|elig) begin
                    sel_next   = pick;
                    state_next = RD;
                end
            end
            RD:        state_next = WAIT_MD;
            WAIT_MD: begin
                if (md_take)
                    state_next = SEND;
                else if (md_expire)
                    state_next = IDLE;
            end
            SEND: begin
                if (in_tx_ready)
                    state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (in_tx_done)
                    state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    // Registered one-hot read strobe, high only for the cycle after RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rden_reg <= 4'b0000;
        else if (state_reg == RD)
            rden_reg <= 4'b0001 << sel_reg;
        else
            rden_reg <= 4'b0000;
    end

    // Metadata wait timer, restarted on every read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt_reg <= '0;
        else if (state_reg == RD)
            to_cnt_reg <= '0;
        else if ((state_reg == WAIT_MD) && !in_md_wr && !md_expire)
            to_cnt_reg <= to_cnt_reg + 1'b1;
    end

    // Metadata capture and hand-off; valid drops on the accepting cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_reg       <= 8'h00;
            md_valid_reg <= 1'b0;
        end else if (md_take) begin
            md_reg       <= in_md;
            md_valid_reg <= 1'b1;
        end else if (tx_xfer) begin
            md_valid_reg <= 1'b0;
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_reg <= 1'b0;
        else if (md_expire)
            err_reg <= 1'b1;
    end

    // Per-queue dequeue counters, bumped when the transmitter accepts.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            // Counter for queue gi, wraps naturally.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_reg <= '0;
                else if (tx_xfer && (sel_reg == 2'(gi)))
                    cnt_reg <= cnt_reg + 1'b1;
            end

            assign out_q_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    assign out_q_rden      = rden_reg;
    assign out_md          = md_reg;
    assign out_md_valid    = md_valid_reg;
    assign out_err_timeout = err_reg;

endmodule

// File: tb/tb_tx_meta_sched.sv
// Directed bench for tx_meta_sched: single read, priority/gating, backpressure,
// metadata timeout, mid-operation reset and (with CBS_EN) the q2 shaper.
module tb_tx_meta_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_q_empty;
    logic [3:0]   in_q_gate;
    logic [10:0]  in_q2_pkt_len;
    logic [3:0]   out_q_rden;
    logic [7:0]   in_md;
    logic         in_md_wr;
    logic [7:0]   out_md;
    logic         out_md_valid;
    logic         in_tx_ready;
    logic         in_tx_done;
    logic [63:0]  out_q_cnt;
    logic         out_err_timeout;

    int           checks = 0;
    int           errors = 0;
    int           rden_viol = 0;
    logic         resp_en = 1'b1;
    logic [7:0]   md_val = 8'h00;
    logic [3:0]   prev_rden = 4'b0000;

    tx_meta_sched dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_q_empty      (in_q_empty),
        .in_q_gate       (in_q_gate),
        .in_q2_pkt_len   (in_q2_pkt_len),
        .out_q_rden      (out_q_rden),
        .in_md           (in_md),
        .in_md_wr        (in_md_wr),
        .out_md          (out_md),
        .out_md_valid    (out_md_valid),
        .in_tx_ready     (in_tx_ready),
        .in_tx_done      (in_tx_done),
        .out_q_cnt       (out_q_cnt),
        .out_err_timeout (out_err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Metadata buffer model: answers one cycle after it sees a strobe.
    initial begin
        logic saw;
        in_md_wr = 1'b0;
        in_md    = 8'h00;
        forever begin
            @(negedge clk);
            saw = (|out_q_rden) & resp_en;
            @(posedge clk);
            #1;
            in_md_wr = saw;
            in_md    = md_val;
        end
    end

    // Strobe rules: one-hot, never back-to-back, never to a gated-off q0.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if ($countones(out_q_rden) > 1) rden_viol++;
                if ((|out_q_rden) && (|prev_rden)) rden_viol++;
                if (out_q_rden[0] && !in_q_gate[0]) rden_viol++;
            end
            prev_rden = out_q_rden;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic wait_rden(input string tag, input logic [3:0] exp);
        int n = 0;
        @(negedge clk);
        while (out_q_rden == 4'b0000 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(tag, {60'd0, out_q_rden}, {60'd0, exp});
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_md_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(tag, {63'd0, out_md_valid}, 64'd1);
    endtask

    task automatic pulse_done();
        in_tx_done = 1'b1;
        @(negedge clk);
        in_tx_done = 1'b0;
    endtask

    initial begin
        int bad;
        rst_n         = 1'b0;
        in_q_empty    = 4'hF;
        in_q_gate     = 4'h0;
        in_q2_pkt_len = 11'd100;
        in_tx_ready   = 1'b0;
        in_tx_done    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rden",  {60'd0, out_q_rden}, 64'd0);
        check("rst_valid", {63'd0, out_md_valid}, 64'd0);
        check("rst_md",    {56'd0, out_md}, 64'd0);
        check("rst_cnt",   out_q_cnt, 64'd0);
        check("rst_err",   {63'd0, out_err_timeout}, 64'd0);

        // Single read from q0 with exact latency
        rst_n = 1'b1;
        @(negedge clk);
        md_val      = 8'h5A;
        in_tx_ready = 1'b1;
        in_q_empty  = 4'b1110;
        in_q_gate   = 4'hF;
        @(negedge clk);
        check("single_rden_early", {60'd0, out_q_rden}, 64'd0);
        @(negedge clk);
        check("single_rden", {60'd0, out_q_rden}, 64'b0001);
        in_q_empty = 4'hF;
        @(negedge clk);
        check("single_valid_early", {63'd0, out_md_valid}, 64'd0);
        @(negedge clk);
        check("single_valid", {63'd0, out_md_valid}, 64'd1);
        check("single_md", {56'd0, out_md}, 64'h5A);
        @(negedge clk);
        check("single_valid_drop", {63'd0, out_md_valid}, 64'd0);
        check("single_cnt", out_q_cnt, 64'h0000_0000_0000_0001);
        pulse_done();

        // Priority with gating: q1 twice while q0 is gated off
        md_val     = 8'h11;
        in_q_empty = 4'b0000;
        in_q_gate  = 4'b1010;
        wait_rden("prio_first", 4'b0010);
        wait_valid("prio_valid1");
        @(negedge clk);
        pulse_done();
        wait_rden("prio_again", 4'b0010);
        wait_valid("prio_valid2");
        @(negedge clk);
        in_q_empty = 4'hF;
        pulse_done();
        check("prio_cnt_q1", {48'd0, out_q_cnt[31:16]}, 64'd2);
        check("prio_cnt_q0", {48'd0, out_q_cnt[15:0]}, 64'd1);

        // Backpressure on q2
        md_val      = 8'hC3;
        in_tx_ready = 1'b0;
        in_q_empty  = 4'b1011;
        in_q_gate   = 4'hF;
        wait_rden("bp_rden", 4'b0100);
        wait_valid("bp_valid");
        check("bp_md", {56'd0, out_md}, 64'hC3);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_md_valid !== 1'b1 || out_md !== 8'hC3 || out_q_rden !== 4'b0000) bad++;
        end
        check("bp_stable", 64'(bad), 64'd0);
        in_tx_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", {63'd0, out_md_valid}, 64'd0);
        check("bp_cnt_q2", {48'd0, out_q_cnt[47:32]}, 64'd1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_q_rden !== 4'b0000) bad++;
        end
        check("bp_hold_no_rden", 64'(bad), 64'd0);
        in_q_empty = 4'hF;
        pulse_done();

        // Metadata timeout on q0, then q1 is served
        resp_en    = 1'b0;
        in_q_empty = 4'b1110;
        wait_rden("to_rden", 4'b0001);
        repeat (7) @(negedge clk);
        check("to_err_early", {63'd0, out_err_timeout}, 64'd0);
        @(negedge clk);
        check("to_err", {63'd0, out_err_timeout}, 64'd1);
        check("to_cnt_same", out_q_cnt, 64'h0000_0001_0002_0001);
        resp_en    = 1'b1;
        md_val     = 8'h42;
        in_q_empty = 4'b1101;
        wait_rden("to_next_rden", 4'b0010);
        wait_valid("to_next_valid");
        check("to_next_md", {56'd0, out_md}, 64'h42);
        @(negedge clk);
        in_q_empty = 4'hF;
        pulse_done();
        check("to_cnt_after", out_q_cnt, 64'h0000_0001_0003_0001);
        check("to_err_sticky", {63'd0, out_err_timeout}, 64'd1);

        // Reset while holding metadata in SEND
        md_val      = 8'h77;
        in_tx_ready = 1'b0;
        in_q_empty  = 4'b1110;
        wait_rden("mrst_rden", 4'b0001);
        wait_valid("mrst_valid");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_valid_now", {63'd0, out_md_valid}, 64'd0);
        check("mrst_cnt", out_q_cnt, 64'd0);
        check("mrst_err", {63'd0, out_err_timeout}, 64'd0);
        in_q_empty = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_tx_ready = 1'b1;
        md_val      = 8'h99;
        in_q_empty  = 4'b1101;
        wait_rden("mrst_idle_rden", 4'b0010);
        wait_valid("mrst_after_valid");
        @(negedge clk);
        in_q_empty = 4'hF;
        pulse_done();
        check("mrst_cnt_after", out_q_cnt, 64'h0000_0000_0001_0000);

`ifdef CBS_EN
        // Shaper: a 100-byte q2 read leaves credit at -100, refilled at 4 per idle cycle
        begin
            int n;
            md_val        = 8'hA5;
            in_q2_pkt_len = 11'd100;
            in_q_empty    = 4'b1011;
            wait_rden("cbs_first", 4'b0100);
            wait_valid("cbs_valid");
            @(negedge clk);
            pulse_done();
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (out_q_rden == 4'b0000 && n < 100);
            check("cbs_gap", 64'(n), 64'd27);
            check("cbs_second", {60'd0, out_q_rden}, 64'b0100);
            in_q_empty = 4'hF;
            wait_valid("cbs_valid2");
            @(negedge clk);
            pulse_done();
        end
`endif

        check("rden_rules", 64'(rden_viol), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
